nonce_sweep_ctrl: RTL and testbench

Sequencer that drives one external double-SHA-256 hash core through a nonce sweep for a single 640-bit block header. It latches a job (header plus 256-bit target), issues one hash per nonce over a start/done handshake, and compares each returned hash against the target. It stops on the first satisfying hash or when the nonce range is exhausted. It sits between the host-facing miner top level and the hash core, and drives the status LED.

---
 rtl/nonce_sweep_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_nonce_sweep_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: sweeps nonces through one external double-SHA-256 core
// and stops on the first hash below target. Optional watchdog: MINER_TIMEOUT_EN.
module nonce_sweep_ctrl #(
    parameter logic [31:0] NONCE_FIRST  = 32'h0000_0000,
    parameter logic [31:0] NONCE_LAST   = 32'hFFFF_FFFF,
    parameter int unsigned CORE_TIMEOUT = 1024
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [639:0] blockHeader,
    input  logic [255:0] target,
    output logic         coreStart,
    output logic [639:0] coreHeader,
    input  logic         coreDone,
    input  logic [255:0] coreHash,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         coreError,
    output logic [31:0]  foundNonce,
    output logic [255:0] satisfactoryHash,
    output logic         ledControl
);

    if (NONCE_FIRST > NONCE_LAST) begin : g_bad_range
        $error("nonce_sweep_ctrl: NONCE_FIRST must not exceed NONCE_LAST");
    end

    if (CORE_TIMEOUT == 0) begin : g_bad_timeout
        $error("nonce_sweep_ctrl: CORE_TIMEOUT must be non-zero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_FOUND,
        S_EXHAUSTED,
        S_ERROR
    } state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    state_t         state_q;
    logic [255:0]   target_q;
    logic [31:0]    nonce_q;
    logic [255:0]   hash_q;
    logic           coreStart_q;
    logic [639:0]   coreHeader_q;
    logic           busy_q;
    logic           found_q;
    logic           exhausted_q;
    logic           coreError_q;
    logic [31:0]    foundNonce_q;
    logic [255:0]   satHash_q;

    logic [31:0]    nonce_d;
    logic           hit_d;
    logic           last_d;

    // The header's own nonce field is replaced by the swept nonce.
    logic           unused_nonce_field;
    assign unused_nonce_field = ^blockHeader[31:0];

    assign nonce_d = nonce_q + 32'd1;
    assign hit_d   = hash_q < target_q;
    assign last_d  = nonce_q == NONCE_LAST;

`ifdef MINER_TIMEOUT_EN
    localparam int WDW = (CORE_TIMEOUT > 1) ? $clog2(CORE_TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(CORE_TIMEOUT - 1);
    logic [WDW-1:0] wd_q;
`endif

    // Sweep sequencer; every output is a register written here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            target_q     <= '0;
            nonce_q      <= NONCE_FIRST;
            hash_q       <= '0;
            coreStart_q  <= 1'b0;
            coreHeader_q <= '0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            coreError_q  <= 1'b0;
            foundNonce_q <= '0;
            satHash_q    <= '0;
`ifdef MINER_TIMEOUT_EN
            wd_q         <= '0;
`endif
        end else begin
            coreStart_q <= 1'b0;
            if (abort) begin
                state_q      <= S_IDLE;
                target_q     <= '0;
                nonce_q      <= NONCE_FIRST;
                coreHeader_q <= '0;
                busy_q       <= 1'b0;
                found_q      <= 1'b0;
                exhausted_q  <= 1'b0;
                coreError_q  <= 1'b0;
                foundNonce_q <= '0;
                satHash_q    <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR: begin
                        if (start) begin
                            state_q      <= S_ISSUE;
                            target_q     <= target;
                            nonce_q      <= NONCE_FIRST;
                            coreHeader_q <= {blockHeader[639:32],
                                             bswap32(NONCE_FIRST)};
                            coreStart_q  <= 1'b1;
                            busy_q       <= 1'b1;
                            found_q      <= 1'b0;
                            exhausted_q  <= 1'b0;
                            coreError_q  <= 1'b0;
                            foundNonce_q <= '0;
                            satHash_q    <= '0;
                        end
                    end
                    S_ISSUE: begin
                        state_q <= S_WAIT;
`ifdef MINER_TIMEOUT_EN
                        wd_q    <= '0;
`endif
                    end
                    S_WAIT: begin
                        if (coreDone) begin
                            hash_q  <= coreHash;
                            state_q <= S_CHECK;
`ifdef MINER_TIMEOUT_EN
                        end else if (wd_q == WD_LAST) begin
                            state_q     <= S_ERROR;
                            coreError_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            wd_q <= wd_q + 1'b1;
`endif
                        end
                    end
                    S_CHECK: begin
                        if (hit_d) begin
                            state_q      <= S_FOUND;
                            found_q      <= 1'b1;
                            foundNonce_q <= nonce_q;
                            satHash_q    <= hash_q;
                            busy_q       <= 1'b0;
                        end else if (last_d) begin
                            state_q     <= S_EXHAUSTED;
                            exhausted_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q      <= S_ISSUE;
                            nonce_q      <= nonce_d;
                            coreHeader_q <= {coreHeader_q[639:32],
                                             bswap32(nonce_d)};
                            coreStart_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign coreStart        = coreStart_q;
    assign coreHeader       = coreHeader_q;
    assign busy             = busy_q;
    assign found            = found_q;
    assign exhausted        = exhausted_q;
    assign coreError        = coreError_q;
    assign foundNonce       = foundNonce_q;
    assign satisfactoryHash = satHash_q;
    assign ledControl       = found_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: behavioural core model plus a job-level
// reference model predicting issue cycles and outcome of each sweep.
module tb_nonce_sweep_ctrl;

    localparam logic [31:0] NF = 32'd5;
    localparam logic [31:0] NL = 32'd9;
    localparam int N  = 5;
    localparam int TO = 16;
`ifdef MINER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clock;
    logic         reset;
    logic         start;
    logic         abort;
    logic [639:0] blockHeader;
    logic [255:0] target;
    logic         coreStart;
    logic [639:0] coreHeader;
    logic         coreDone;
    logic [255:0] coreHash;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic         coreError;
    logic [31:0]  foundNonce;
    logic [255:0] satisfactoryHash;
    logic         ledControl;

    nonce_sweep_ctrl #(
        .NONCE_FIRST (NF),
        .NONCE_LAST  (NL),
        .CORE_TIMEOUT(TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .blockHeader     (blockHeader),
        .target          (target),
        .coreStart       (coreStart),
        .coreHeader      (coreHeader),
        .coreDone        (coreDone),
        .coreHash        (coreHash),
        .busy            (busy),
        .found           (found),
        .exhausted       (exhausted),
        .coreError       (coreError),
        .foundNonce      (foundNonce),
        .satisfactoryHash(satisfactoryHash),
        .ledControl      (ledControl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [639:0] got,
                       input logic [639:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    task automatic tick;
        @(negedge clock);
    endtask

    // Per-job core behaviour, indexed by nonce - NF. Latency 0 = silent.
    logic [255:0] hash_tab [N];
    int           lat_tab  [N];

    int           core_cnt = 0;
    int           core_idx = 0;
    logic [639:0] core_hdr;
    logic [31:0]  issue_n[$];

    // Hash core model: answers each coreStart after lat_tab cycles.
    always @(negedge clock) begin
        coreDone = 1'b0;
        coreHash = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
        if (reset) begin
            core_cnt = 0;
        end else begin
            if (core_cnt > 0) begin
                if (busy) chk("hdr_stable", coreHeader, core_hdr);
                core_cnt--;
                if (core_cnt == 0) begin
                    coreDone = 1'b1;
                    if (core_idx >= 0 && core_idx < N)
                        coreHash = hash_tab[core_idx];
                end
            end
            if (coreStart) begin
                issue_n.push_back(bswap32(coreHeader[31:0]));
                core_idx = int'(bswap32(coreHeader[31:0]) - NF);
                core_hdr = coreHeader;
                if (core_idx >= 0 && core_idx < N)
                    core_cnt = lat_tab[core_idx];
                else
                    core_cnt = 1;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_coreStart"}, 640'(coreStart), '0);
        chk({tag, "_busy"}, 640'(busy), '0);
        chk({tag, "_found"}, 640'(found), '0);
        chk({tag, "_exhausted"}, 640'(exhausted), '0);
        chk({tag, "_coreError"}, 640'(coreError), '0);
        chk({tag, "_foundNonce"}, 640'(foundNonce), '0);
        chk({tag, "_satHash"}, 640'(satisfactoryHash), '0);
        chk({tag, "_coreHeader"}, coreHeader, '0);
        chk({tag, "_led"}, 640'(ledControl), '0);
    endtask

    // Runs one job from a negedge; predicts issue cycles and outcome.
    task automatic run_job(input logic [639:0] hdr, input logic [255:0] tgt);
        int s, t, e, outc, idx;
        int exp_iss[$];
        bit is_iss;
        s    = cyc;
        t    = s + 1;
        e    = 0;
        idx  = -1;
        outc = 1;
        for (int i = 0; i < N; i++) begin
            exp_iss.push_back(t);
            if (TO_EN && (lat_tab[i] == 0 || lat_tab[i] > TO)) begin
                outc = 2;
                e    = t + TO + 1;
                break;
            end
            if (hash_tab[i] < tgt) begin
                outc = 0;
                idx  = i;
                e    = t + lat_tab[i] + 2;
                break;
            end
            if (i == N - 1) e = t + lat_tab[i] + 2;
            t += lat_tab[i] + 2;
        end
        issue_n.delete();
        blockHeader = hdr;
        target      = tgt;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        blockHeader = {20{$urandom}};
        target      = {8{$urandom}};
        while (cyc <= e + 1) begin
            is_iss = 1'b0;
            foreach (exp_iss[k]) if (exp_iss[k] == cyc) is_iss = 1'b1;
            chk("coreStart", 640'(coreStart), 640'(is_iss));
            chk("busy", 640'(busy), 640'(cyc < e));
            chk("found", 640'(found), 640'(outc == 0 && cyc >= e));
            chk("exhausted", 640'(exhausted), 640'(outc == 1 && cyc >= e));
            chk("coreError", 640'(coreError), 640'(outc == 2 && cyc >= e));
            chk("led", 640'(ledControl), 640'(outc == 0 && cyc >= e));
            tick();
        end
        chk("foundNonce", 640'(foundNonce),
            (outc == 0) ? 640'(NF + 32'(idx)) : '0);
        chk("satHash", 640'(satisfactoryHash),
            (outc == 0) ? 640'(hash_tab[idx]) : '0);
        chk("n_issued", 640'(issue_n.size()), 640'(exp_iss.size()));
        foreach (issue_n[k]) chk("issued_nonce", 640'(issue_n[k]), 640'(NF + 32'(k)));
        chk("hdr_upper", 640'(coreHeader[639:32]), 640'(hdr[639:32]));
        chk("hdr_nonce", 640'(coreHeader[31:0]),
            640'(bswap32(NF + 32'(exp_iss.size() - 1))));
    endtask

    task automatic gen_job(output logic [255:0] tgt);
        int c;
        tgt = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) tgt = '0;
        for (int i = 0; i < N; i++) begin
            c = $urandom_range(0, 5);
            if (c == 0 && tgt != '0)
                hash_tab[i] = tgt - 256'($urandom_range(1, 100));
            else if (c == 1 || ~tgt < 256'd200)
                hash_tab[i] = tgt;
            else
                hash_tab[i] = tgt + 256'($urandom_range(1, 100));
            lat_tab[i] = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(1, 6);
        end
    endtask

    logic [255:0] tg;

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        blockHeader = '0;
        target      = '0;
        coreDone    = 1'b0;
        coreHash    = '0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Hit on the first nonce with an all-ones target.
        tg = '1;
        for (int i = 0; i < N; i++) begin
            hash_tab[i] = tg - 256'(i + 1);
            lat_tab[i]  = 3;
        end
        run_job({20{$urandom}}, tg);
        chk("first_hdr_nonce", 640'(coreHeader[31:0]), 640'(32'h0500_0000));

        // Zero target: whole range swept, no hit.
        tg = '0;
        for (int i = 0; i < N; i++) begin
            hash_tab[i] = 256'(i);
            lat_tab[i]  = 2;
        end
        run_job({20{$urandom}}, tg);

        // Equality is not a hit; target - 1 is.
        tg = {8{$urandom}} | 256'd1;
        for (int i = 0; i < N; i++) begin
            hash_tab[i] = tg;
            lat_tab[i]  = 1;
        end
        hash_tab[1] = tg - 256'd1;
        run_job({20{$urandom}}, tg);

        // Abort in WAIT, with the core answering two cycles later.
        for (int i = 0; i < N; i++) begin
            hash_tab[i] = '0;
            lat_tab[i]  = 4;
        end
        issue_n.delete();
        blockHeader = {20{$urandom}};
        target      = '1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("abort_busy", 640'(busy), '0);
            chk("abort_coreStart", 640'(coreStart), '0);
            chk("abort_found", 640'(found), '0);
            chk("abort_exhausted", 640'(exhausted), '0);
            tick();
        end
        chk("abort_issued", 640'(issue_n.size()), 640'(1));
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("startabort_busy", 640'(busy), '0);
            chk("startabort_coreStart", 640'(coreStart), '0);
            tick();
        end
        chk("startabort_issued", 640'(issue_n.size()), 640'(1));

        // Abort clears a standing found.
        for (int i = 0; i < N; i++) begin
            hash_tab[i] = 256'd7;
            lat_tab[i]  = 2;
        end
        run_job({20{$urandom}}, 256'd100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_found_clr", 640'(found), '0);
        chk("abort_led_clr", 640'(ledControl), '0);

        // Asynchronous reset while in CHECK.
        for (int i = 0; i < N; i++) begin
            hash_tab[i] = '1;
            lat_tab[i]  = 2;
        end
        blockHeader = {20{$urandom}};
        target      = 256'd1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        tick();
        reset = 1'b0;
        chk_all_zero("post_reset");
        tick();
        hash_tab[0] = '0;
        run_job({20{$urandom}}, 256'd50);

        // Latency right at the watchdog limit, then one past it.
        for (int i = 0; i < N; i++) begin
            hash_tab[i] = '1;
            lat_tab[i]  = 1;
        end
        hash_tab[1] = '0;
        lat_tab[0]  = TO;
        run_job({20{$urandom}}, 256'd9);
        lat_tab[0]  = TO + 1;
        run_job({20{$urandom}}, 256'd9);
`ifdef MINER_TIMEOUT_EN
        // Silent core: watchdog fires, next start clears and reissues.
        lat_tab[0] = 0;
        run_job({20{$urandom}}, 256'd9);
        lat_tab[0] = 2;
        run_job({20{$urandom}}, 256'd9);
`endif

        for (int j = 0; j < 14; j++) begin
            gen_job(tg);
            run_job({20{$urandom}}, tg);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
